// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
package pipe_pkg;

    localparam int          EXC_W        = 5;
    localparam int          INSTR_W      = 32;
    localparam int          PC_W         = 32;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Fixed-width part of one pipeline entry; the payload travels alongside
    // because its width is a per-instance parameter.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [EXC_W-1:0]   exc;
        logic               bd;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // A faulting instruction must never reach execute as a live opcode.
    function automatic entry_t sanitise(input logic [INSTR_W-1:0] instr,
                                        input logic [PC_W-1:0]    pc,
                                        input logic [EXC_W-1:0]   exc,
                                        input logic               bd);
        entry_t e;
        e.instr = (exc != '0) ? NOP_WORD : instr;
        e.pc    = pc;
        e.exc   = exc;
        e.bd    = bd;
        return e;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One entry register (fixed fields + payload) with load and clear.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = 96,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  entry_t               d_entry,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output entry_t               q_entry,
    output logic [PAYLOAD_W-1:0] q_payload
);

    // Entry storage; clear has priority over load.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_entry.instr <= NOP_WORD;
            q_entry.pc    <= RESET_PC;
            q_entry.exc   <= '0;
            q_entry.bd    <= 1'b0;
            q_payload     <= '0;
        end else if (load) begin
            q_entry   <= d_entry;
            q_payload <= d_payload;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble
// insertion and an optional second (skid) entry.
//
//  state    | meaning
//  ---------+---------------------------------------------
//  ST_EMPTY | no entry held, out_valid low
//  ST_ONE   | head holds the only entry
//  ST_TWO   | head plus an older-than-input skid entry; input blocked
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = 96,
    parameter int          SKID      = 1,
    parameter logic [31:0] EXC_PC    = EXC_PC_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_req,
    input  logic                 bubble,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic [4:0]           in_exc,
    input  logic                 in_bd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_pc,
    output logic [4:0]           out_exc,
    output logic                 out_bd,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
);

    localparam bit HAS_SKID = (SKID != 0);

    occ_state_e           state_q, state_n;
    entry_t               in_entry, head_d, head_q, skid_q;
    logic [PAYLOAD_W-1:0] head_pl_d, head_pl_q, skid_pl_q;
    logic                 head_load, skid_load, skid_clear;
    logic                 room, accept, drain, out_valid_i;

    assign out_valid_i = (state_q != ST_EMPTY);

    // With the skid entry, readiness depends only on registered state so
    // out_ready never reaches in_ready combinationally.
    assign room     = HAS_SKID ? (state_q != ST_TWO) : (~out_valid_i | out_ready);
    assign in_ready = room & ~reset & ~flush_req & ~bubble;

    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_i & out_ready;
    assign in_entry = sanitise(in_instr, in_pc, in_exc, in_bd);

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_n;
    end

    // Next state and slot controls, priority flush > bubble > handshake.
    always_comb begin
        state_n    = state_q;
        head_load  = 1'b0;
        head_d     = in_entry;
        head_pl_d  = in_payload;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush_req) begin
            state_n      = ST_ONE;
            head_load    = 1'b1;
            head_d.instr = NOP_WORD;
            head_d.pc    = EXC_PC;
            head_d.exc   = '0;
            head_d.bd    = 1'b0;
            head_pl_d    = '0;
            skid_clear   = 1'b1;
        end else if (bubble) begin
            // The bubble only replaces the head when it is free this cycle;
            // a held skid entry stays queued behind it.
            if (state_q == ST_EMPTY || drain) begin
                head_load    = 1'b1;
                head_d.instr = NOP_WORD;
                head_d.pc    = in_pc;
                head_d.exc   = '0;
                head_d.bd    = in_bd;
                head_pl_d    = '0;
                if (state_q == ST_EMPTY) state_n = ST_ONE;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        state_n   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_n   = ST_TWO;
                    end else if (drain) begin
                        state_n   = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        head_load = 1'b1;
                        head_d    = skid_q;
                        head_pl_d = skid_pl_q;
                        state_n   = ST_ONE;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    pipe_skid_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .RESET_PC  (RESET_PC)
    ) u_head (
        .clk       (clk),
        .reset     (reset),
        .load      (head_load),
        .clear     (1'b0),
        .d_entry   (head_d),
        .d_payload (head_pl_d),
        .q_entry   (head_q),
        .q_payload (head_pl_q)
    );

    generate
        if (HAS_SKID) begin : g_skid
            pipe_skid_slot #(
                .PAYLOAD_W (PAYLOAD_W),
                .RESET_PC  (32'h0)
            ) u_skid (
                .clk       (clk),
                .reset     (reset),
                .load      (skid_load),
                .clear     (skid_clear),
                .d_entry   (in_entry),
                .d_payload (in_payload),
                .q_entry   (skid_q),
                .q_payload (skid_pl_q)
            );
        end else begin : g_no_skid
            assign skid_q    = '0;
            assign skid_pl_q = '0;
        end
    endgenerate

    assign out_valid   = out_valid_i;
    assign out_instr   = head_q.instr;
    assign out_pc      = head_q.pc;
    assign out_exc     = head_q.exc;
    assign out_bd      = head_q.bd;
    assign out_payload = head_pl_q;
    assign occupancy   = state_q;

endmodule
